// File: rtl/pool_window_gather_pkg.sv
// Shared constants for the 2x2 pooling datapath: pixel width, LeNet layer sizes
// and the slot order used to pack a window into one word.
package pool_window_gather_pkg;

  localparam int DATA_SIZE = 8;

  localparam int CONV1_IMG_W = 28;
  localparam int CONV1_IMG_H = 28;
  localparam int CONV2_IMG_W = 10;
  localparam int CONV2_IMG_H = 10;

  // Slot k of a packed window occupies bits [(k+1)*DATA_SIZE-1 : k*DATA_SIZE].
  localparam int WIN_TL = 3;
  localparam int WIN_TR = 2;
  localparam int WIN_BL = 1;
  localparam int WIN_BR = 0;

endpackage

// File: rtl/pool_window_gather_if.sv
// Pixel-in / window-out handshake bundle between the activation stage,
// pool_window_gather and the max-pool stage.
interface pool_window_gather_if #(
  parameter int DATA_SIZE = pool_window_gather_pkg::DATA_SIZE
);
  logic [DATA_SIZE-1:0]   in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [4*DATA_SIZE-1:0] win_data;
  logic                   win_valid;
  logic                   win_ready;
  logic                   frame_done;

  modport master (
    output in_data, in_valid, win_ready,
    input  in_ready, win_data, win_valid, frame_done
  );

  modport slave (
    input  in_data, in_valid, win_ready,
    output in_ready, win_data, win_valid, frame_done
  );
endinterface

// File: rtl/pool_line_buffer.sv
// One-row pixel store: single synchronous write port, two asynchronous read
// ports so both top pixels of a window are available in the same cycle.
module pool_line_buffer #(
  parameter  int DATA_SIZE = 8,
  parameter  int DEPTH     = 28,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr_a,
  output logic [DATA_SIZE-1:0] rdata_a,
  input  logic [ADDR_W-1:0]    raddr_b,
  output logic [DATA_SIZE-1:0] rdata_b
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // NOTE: the RAM has no reset; every entry is rewritten by an even row before
  // any odd row reads it, and a reset port would prevent distributed-RAM mapping.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/pool_window_gather.sv
// Buffers one row plus one pixel of a raster stream and emits each 2x2 window.
// Define POOL_GATHER_RELU_EN to clamp negative pixels to zero on entry.
module pool_window_gather
  import pool_window_gather_pkg::*;
#(
  parameter int DATA_SIZE = pool_window_gather_pkg::DATA_SIZE,
  parameter int IMG_W     = CONV1_IMG_W,
  parameter int IMG_H     = CONV1_IMG_H
) (
  input logic                 clk,
  input logic                 rst,
  pool_window_gather_if.slave bus
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_dims
    $error("pool_window_gather: IMG_W and IMG_H must be even and >= 2");
  end

  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic [DATA_SIZE-1:0]   pix;
  logic [DATA_SIZE-1:0]   held;
  logic [DATA_SIZE-1:0]   top_left;
  logic [DATA_SIZE-1:0]   top_right;
  logic [COL_W-1:0]       left_addr;
  logic [4*DATA_SIZE-1:0] next_win;
  logic                   accept;
  logic                   col_last;
  logic                   row_last;
  logic                   load_win;
  logic                   buf_we;
  logic                   last_pending;

  // A slot frees up either when empty or when it drains this same edge.
  assign bus.in_ready = !bus.win_valid || bus.win_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign col_last     = (col == COL_W'(IMG_W - 1));
  assign row_last     = (row == ROW_W'(IMG_H - 1));
  assign load_win     = accept && row[0] && col[0];
  assign buf_we       = accept && !row[0];
  assign left_addr    = col & ~COL_W'(1);

  // NOTE: give every always_comb output a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pix = bus.in_data;
`ifdef POOL_GATHER_RELU_EN
    if (bus.in_data[DATA_SIZE-1]) pix = '0;
`endif
  end

  always_comb begin
    next_win = '0;
    next_win[WIN_TL*DATA_SIZE +: DATA_SIZE] = top_left;
    next_win[WIN_TR*DATA_SIZE +: DATA_SIZE] = top_right;
    next_win[WIN_BL*DATA_SIZE +: DATA_SIZE] = held;
    next_win[WIN_BR*DATA_SIZE +: DATA_SIZE] = pix;
  end

  pool_line_buffer #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (IMG_W)
  ) u_line_buf (
    .clk     (clk),
    .we      (buf_we),
    .waddr   (col),
    .wdata   (pix),
    .raddr_a (left_addr),
    .rdata_a (top_left),
    .raddr_b (col),
    .rdata_b (top_right)
  );

  // NOTE: state registers use non-blocking assignments so every read in this
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col            <= '0;
      row            <= '0;
      held           <= '0;
      last_pending   <= 1'b0;
      bus.win_data   <= '0;
      bus.win_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      if (bus.win_valid && bus.win_ready && last_pending) begin
        bus.frame_done <= 1'b1;
        last_pending   <= 1'b0;
      end

      if (load_win) begin
        bus.win_data  <= next_win;
        bus.win_valid <= 1'b1;
      end else if (bus.win_ready) begin
        bus.win_valid <= 1'b0;
      end

      if (accept) begin
        if (row[0] && !col[0]) held <= pix;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
          if (row_last) last_pending <= 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
